// File: rtl/e_mdu_pkg.sv
// Shared constants for the E-stage multiply/divide unit: MDOp codes, default latencies, HiLoSel encoding.
// Optional feature macro: MDU_MADD_EN (accepts MADD/MADDU as multi-cycle ops).
package e_mdu_pkg;

  localparam logic [3:0] MDOP_NONE  = 4'd0;
  localparam logic [3:0] MDOP_MULT  = 4'd1;
  localparam logic [3:0] MDOP_MULTU = 4'd2;
  localparam logic [3:0] MDOP_DIV   = 4'd3;
  localparam logic [3:0] MDOP_DIVU  = 4'd4;
  localparam logic [3:0] MDOP_MTHI  = 4'd5;
  localparam logic [3:0] MDOP_MTLO  = 4'd6;
  localparam logic [3:0] MDOP_MADD  = 4'd7;
  localparam logic [3:0] MDOP_MADDU = 4'd8;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  localparam logic HILO_LO = 1'b0;
  localparam logic HILO_HI = 1'b1;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } mdu_state_e;

  function automatic logic is_mult_class(input logic [3:0] op);
    logic r;
    r = (op == MDOP_MULT) || (op == MDOP_MULTU);
`ifdef MDU_MADD_EN
    r = r || (op == MDOP_MADD) || (op == MDOP_MADDU);
`endif
    return r;
  endfunction

  function automatic logic is_div_class(input logic [3:0] op);
    return (op == MDOP_DIV) || (op == MDOP_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_arith.sv
// Combinational result datapath: maps latched op/operands and current HI/LO to the next HI/LO and a write enable.
// Optional feature macro: MDU_MADD_EN (adds accumulate into {HI, LO}).
module e_mdu_arith
  import e_mdu_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [31:0] next_hi_o,
  output logic [31:0] next_lo_o,
  output logic        we_o
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        div_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] quot;
  logic [31:0] rem;

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
  assign prod_u = {32'd0, a_i} * {32'd0, b_i};

  // Sign-magnitude division; handles 0x80000000 / -1 without overflow since magnitudes are unsigned.
  assign div_signed = (op_i == MDOP_DIV);
  assign a_neg      = div_signed & a_i[31];
  assign b_neg      = div_signed & b_i[31];
  assign a_mag      = a_neg ? -a_i : a_i;
  assign b_mag      = (b_i == '0) ? 32'd1 : (b_neg ? -b_i : b_i);
  assign uq         = a_mag / b_mag;
  assign ur         = a_mag % b_mag;
  assign quot       = (a_neg ^ b_neg) ? -uq : uq;
  assign rem        = a_neg ? -ur : ur;

  always_comb begin
    next_hi_o = hi_i;
    next_lo_o = lo_i;
    we_o      = 1'b0;
    case (op_i)
      MDOP_MULT: begin
        {next_hi_o, next_lo_o} = prod_s;
        we_o = 1'b1;
      end
      MDOP_MULTU: begin
        {next_hi_o, next_lo_o} = prod_u;
        we_o = 1'b1;
      end
      MDOP_DIV, MDOP_DIVU: begin
        if (b_i != '0) begin
          next_lo_o = quot;
          next_hi_o = rem;
          we_o      = 1'b1;
        end
      end
`ifdef MDU_MADD_EN
      MDOP_MADD: begin
        {next_hi_o, next_lo_o} = {hi_i, lo_i} + prod_s;
        we_o = 1'b1;
      end
      MDOP_MADDU: begin
        {next_hi_o, next_lo_o} = {hi_i, lo_i} + prod_u;
        we_o = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: IDLE/RUN FSM with down-counter, HI/LO registers, MDOut read mux.
// Optional feature macro: MDU_MADD_EN (MADD/MADDU accepted with MULT_CYCLES latency).
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HiLoSel,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic [31:0] ar_hi;
  logic [31:0] ar_lo;
  logic        ar_we;

  e_mdu_arith u_arith (
    .op_i      (op_q),
    .a_i       (a_q),
    .b_i       (b_q),
    .hi_i      (hi_q),
    .lo_i      (lo_q),
    .next_hi_o (ar_hi),
    .next_lo_o (ar_lo),
    .we_o      (ar_we)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (Start && (is_mult_class(MDOp) || is_div_class(MDOp))) begin
          op_d    = MDOp;
          a_d     = A;
          b_d     = B;
          cnt_d   = is_div_class(MDOp) ? DIV_LOAD : MULT_LOAD;
          state_d = ST_RUN;
        end else if (MDOp == MDOP_MTHI) begin
          hi_d = A;
        end else if (MDOp == MDOP_MTLO) begin
          lo_d = A;
        end
      end
      ST_RUN: begin
        // All new ops, including mthi/mtlo, are dropped until the result lands.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (ar_we) begin
            hi_d = ar_hi;
            lo_d = ar_lo;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= MDOP_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Busy  = (state_q == ST_RUN);
  assign HI    = hi_q;
  assign LO    = lo_q;
  assign MDOut = (HiLoSel == HILO_HI) ? hi_q : lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: expected HI/LO queued at issue, compared when Busy falls.
// Optional feature macro: MDU_MADD_EN (selects the MADDU expectation).
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [3:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        HiLoSel;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDOut;

  always #5 clk = ~clk;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .Start   (Start),
    .MDOp    (MDOp),
    .A       (A),
    .B       (B),
    .HiLoSel (HiLoSel),
    .Busy    (Busy),
    .HI      (HI),
    .LO      (LO),
    .MDOut   (MDOut)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  logic rst_edge = 1'b1;

  always @(posedge clk) rst_edge <= reset;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: a Busy falling edge not caused by reset is a completed op.
  initial begin
    logic busy_prev;
    exp_t e;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (busy_prev && !Busy && !rst_edge) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: got HI=%h LO=%h, expected no completion", HI, LO);
        end else begin
          e = sb.pop_front();
          check("result_hi", HI, e.hi);
          check("result_lo", LO, e.lo);
        end
      end
      busy_prev = Busy;
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Start = 1'b1;
    MDOp  = op;
    A     = a;
    B     = b;
    @(negedge clk);
    Start = 1'b0;
    MDOp  = MDOP_NONE;
  endtask

  task automatic busy_run(input string name, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      check(name, 32'(Busy), 32'd1);
      @(negedge clk);
    end
    check({name, "_end"}, 32'(Busy), 32'd0);
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int unsigned n,
                        input logic [31:0] ehi, input logic [31:0] elo);
    exp_t e;
    e.hi = ehi;
    e.lo = elo;
    sb.push_back(e);
    issue(op, a, b);
    busy_run(name, n);
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] a);
    @(negedge clk);
    MDOp = op;
    A    = a;
    @(negedge clk);
    MDOp = MDOP_NONE;
  endtask

  initial begin
    exp_t e;
    reset   = 1'b1;
    Start   = 1'b0;
    MDOp    = MDOP_NONE;
    A       = '0;
    B       = '0;
    HiLoSel = HILO_LO;
    repeat (3) @(negedge clk);
    check("reset_hi", HI, 32'h0);
    check("reset_lo", LO, 32'h0);
    check("reset_busy", 32'(Busy), 32'd0);
    reset = 1'b0;

    run_op("mult_busy",  MDOP_MULT,  32'hFFFFFFFE, 32'd3,        5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu_busy", MDOP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001);
    run_op("div_busy",   MDOP_DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu0_busy", MDOP_DIVU,  32'h00001234, 32'd0,        10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divovf_busy", MDOP_DIV,  32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
    run_op("divneg_busy", MDOP_DIV,  32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);

    mt(MDOP_MTHI, 32'h12345678);
    check("mthi_hi", HI, 32'h12345678);
    check("mthi_busy", 32'(Busy), 32'd0);
    mt(MDOP_MTLO, 32'h9ABCDEF0);
    check("mtlo_lo", LO, 32'h9ABCDEF0);
    check("mtlo_hi_kept", HI, 32'h12345678);
    check("mtlo_busy", 32'(Busy), 32'd0);
    HiLoSel = HILO_HI;
    #1 check("mdout_hi", MDOut, 32'h12345678);
    HiLoSel = HILO_LO;
    #1 check("mdout_lo", MDOut, 32'h9ABCDEF0);

    // DIV 100/7 with a MULT and an MTLO injected mid-flight; both must be ignored.
    e.hi = 32'd2;
    e.lo = 32'd14;
    sb.push_back(e);
    issue(MDOP_DIV, 32'd100, 32'd7);
    for (int unsigned i = 0; i < 10; i++) begin
      check("ign_busy", 32'(Busy), 32'd1);
      if (i == 2) begin
        Start = 1'b1; MDOp = MDOP_MULT; A = 32'hDEADBEEF; B = 32'd2;
      end else if (i == 3) begin
        Start = 1'b0; MDOp = MDOP_MTLO; A = 32'hDEADBEEF;
      end else if (i == 4) begin
        MDOp = MDOP_NONE;
      end
      @(negedge clk);
      if (i == 4) check("ign_mtlo_lo", LO, 32'h9ABCDEF0);
    end
    check("ign_busy_end", 32'(Busy), 32'd0);
    @(negedge clk);
    check("ign_no_restart", 32'(Busy), 32'd0);

    // Abort a MULT with reset in T+3.
    issue(MDOP_MULT, 32'd3, 32'd4);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_hi", HI, 32'h0);
    check("abort_lo", LO, 32'h0);
    check("abort_busy", 32'(Busy), 32'd0);
    repeat (8) @(negedge clk);
    check("abort_hi_late", HI, 32'h0);
    check("abort_lo_late", LO, 32'h0);
    check("abort_busy_late", 32'(Busy), 32'd0);

    mt(MDOP_MTHI, 32'h0);
    mt(MDOP_MTLO, 32'hFFFFFFFF);
    check("madd_pre_lo", LO, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
    run_op("maddu_busy", MDOP_MADDU, 32'd1, 32'd1, 5, 32'h00000001, 32'h00000000);
`else
    issue(MDOP_MADDU, 32'd1, 32'd1);
    for (int unsigned i = 0; i < 6; i++) begin
      check("maddu_off_busy", 32'(Busy), 32'd0);
      @(negedge clk);
    end
    check("maddu_off_hi", HI, 32'h0);
    check("maddu_off_lo", LO, 32'hFFFFFFFF);
`endif

    for (int unsigned i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending results, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
